// File: rtl/ring_port_arbiter_if.sv
// Flit bus for the three-port ring arbiter: per-input offers with grants,
// and registered per-output flits with downstream accepts.
interface ring_port_arbiter_if #(
    parameter int DW = 16
);
    logic [2:0]      in_valid;
    logic [11:0]     in_dest;
    logic [3*DW-1:0] in_data;
    logic [2:0]      in_ready;
    logic [2:0]      out_valid;
    logic [3*DW-1:0] out_data;
    logic [2:0]      out_ready;

    modport master (
        output in_valid, in_dest, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_dest, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ring_port_arbiter.sv
// Ring node switch: routes local/west/east flits toward the shorter way round
// the ring, and round-robin arbitrates each of the three registered outputs.
module ring_port_arbiter #(
    parameter logic [3:0] ADDR = 4'd0,
    parameter logic [3:0] N    = 4'd8,
    parameter int         DW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    ring_port_arbiter_if.slave bus,
    output logic               route_err
);
    localparam logic [1:0] PORT_LOCAL = 2'd0;
    localparam logic [1:0] PORT_WEST  = 2'd1;
    localparam logic [1:0] PORT_EAST  = 2'd2;

    // Shortest way round the ring; a tie goes the long-address way round.
    function automatic logic [1:0] route_of(input logic [3:0] dest);
        logic [3:0] diff;
        logic [3:0] ndiff;
        diff  = (dest > ADDR) ? dest - ADDR : ADDR - dest;
        ndiff = N - diff;
        if (dest >= N || dest == ADDR)
            route_of = PORT_LOCAL;
        else if (dest < ADDR)
            route_of = (diff >= ndiff) ? PORT_EAST : PORT_WEST;
        else
            route_of = (diff >= ndiff) ? PORT_WEST : PORT_EAST;
    endfunction

    // Returns {found, index}; walking k downward lets the nearest candidate win.
    function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] idx;
        rr_pick = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'd3)
                idx = idx - 3'd3;
            if (req[idx[1:0]])
                rr_pick = {1'b1, idx[1:0]};
        end
    endfunction

    logic [2:0][1:0] route;
    logic [2:0][2:0] req;
    logic [2:0][2:0] pick;
    logic [2:0]      free;
    logic [2:0]      in_ready;
    logic            bad_accept;

    logic [2:0]      out_valid_q, out_valid_d;
    logic [3*DW-1:0] out_data_q, out_data_d;
    logic [2:0][1:0] ptr_q, ptr_d;
    logic            route_err_q, route_err_d;

    always_comb begin
        route      = '0;
        req        = '0;
        pick       = '0;
        free       = '0;
        in_ready   = '0;
        bad_accept = 1'b0;
        for (int i = 0; i < 3; i++)
            route[i] = route_of(bus.in_dest[4*i +: 4]);
        for (int o = 0; o < 3; o++) begin
            free[o] = !out_valid_q[o] || bus.out_ready[o];
            for (int i = 0; i < 3; i++)
                req[o][i] = bus.in_valid[i] && (route[i] == 2'(o));
            pick[o] = rr_pick(req[o], ptr_q[o]);
        end
        for (int i = 0; i < 3; i++) begin
            in_ready[i] = rst && free[route[i]] && pick[route[i]][2]
                          && (pick[route[i]][1:0] == 2'(i));
            if (in_ready[i] && bus.in_dest[4*i +: 4] >= N)
                bad_accept = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
        route_err_d = route_err_q || bad_accept;
        for (int o = 0; o < 3; o++) begin
            if (free[o]) begin
                if (pick[o][2]) begin
                    out_valid_d[o]          = 1'b1;
                    out_data_d[DW*o +: DW]  = bus.in_data[DW*pick[o][1:0] +: DW];
                    ptr_d[o]                = (pick[o][1:0] == 2'd2) ? 2'd0 : pick[o][1:0] + 2'd1;
                end else begin
                    out_valid_d[o] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            ptr_q       <= '0;
            route_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
            route_err_q <= route_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign route_err     = route_err_q;
endmodule

// File: tb/tb_ring_port_arbiter.sv
// Directed and randomized checks of ring_port_arbiter (N=8, ADDR=2) against a
// hop-counting ring model with per-output round-robin queues of candidates.
module tb_ring_port_arbiter;
    localparam logic [3:0] ADDR = 4'd2;
    localparam logic [3:0] N    = 4'd8;
    localparam int         DW   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic route_err;
    int   total = 0;
    int   bad   = 0;

    bit            m_valid [3];
    logic [DW-1:0] m_data  [3];
    int            m_ptr   [3];
    bit            m_err;
    int            m_grant [3];
    logic [2:0]    exp_ready;

    ring_port_arbiter_if #(.DW(DW)) bus ();

    ring_port_arbiter #(.ADDR(ADDR), .N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .route_err (route_err)
    );

    always #5 clk = ~clk;

    // Counts hops each way round the ring and takes the shorter one.
    function automatic int model_route(input int dest);
        int east_hops;
        int west_hops;
        if (dest >= int'(N) || dest == int'(ADDR))
            return 0;
        east_hops = (dest - int'(ADDR) + int'(N)) % int'(N);
        west_hops = (int'(ADDR) - dest + int'(N)) % int'(N);
        if (east_hops < west_hops)
            return 2;
        if (west_hops < east_hops)
            return 1;
        return (dest > int'(ADDR)) ? 1 : 2;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < 3; o++) begin
            m_valid[o] = 1'b0;
            m_data[o]  = '0;
            m_ptr[o]   = 0;
            m_grant[o] = -1;
        end
        m_err = 1'b0;
    endtask

    task automatic model_eval();
        int idx;
        exp_ready = '0;
        for (int o = 0; o < 3; o++) begin
            m_grant[o] = -1;
            if (!m_valid[o] || bus.out_ready[o]) begin
                for (int k = 0; k < 3; k++) begin
                    idx = (m_ptr[o] + k) % 3;
                    if (m_grant[o] < 0 && bus.in_valid[idx]
                        && model_route(int'(bus.in_dest[4*idx +: 4])) == o)
                        m_grant[o] = idx;
                end
            end
            if (m_grant[o] >= 0)
                exp_ready[m_grant[o]] = 1'b1;
        end
    endtask

    task automatic model_update();
        int g;
        for (int o = 0; o < 3; o++) begin
            g = m_grant[o];
            if (!m_valid[o] || bus.out_ready[o]) begin
                if (g >= 0) begin
                    m_valid[o] = 1'b1;
                    m_data[o]  = bus.in_data[DW*g +: DW];
                    m_ptr[o]   = (g + 1) % 3;
                    if (int'(bus.in_dest[4*g +: 4]) >= int'(N))
                        m_err = 1'b1;
                end else begin
                    m_valid[o] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] valid, input logic [11:0] dest,
                                  input logic [3*DW-1:0] data, input logic [2:0] ready);
        bus.in_valid  = valid;
        bus.in_dest   = dest;
        bus.in_data   = data;
        bus.out_ready = ready;
    endtask

    // One clock: grant check before the edge, registered outputs just after it.
    task automatic cycle(input string tag);
        #1;
        model_eval();
        check_output({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        model_update();
        check_output({tag, ".out_valid"}, 64'(bus.out_valid), 64'({m_valid[2], m_valid[1], m_valid[0]}));
        check_output({tag, ".out_data"}, 64'(bus.out_data), 64'({m_data[2], m_data[1], m_data[0]}));
        check_output({tag, ".route_err"}, 64'(route_err), 64'(m_err));
    endtask

    initial begin
        logic [3:0] local_dest [4];
        int         local_port [4];
        logic [2:0] rr_seq     [4];
        local_dest = '{4'd6, 4'd5, 4'd0, 4'd3};
        local_port = '{1, 2, 1, 2};
        rr_seq     = '{3'b001, 3'b010, 3'b100, 3'b001};

        $display("[TB] start");
        model_reset();
        apply_stimulus(3'b111, {4'd3, 4'd3, 4'd3}, 48'h0C2_00C1_00C0, 3'b111);
        repeat (2) @(posedge clk);
        #1;
        check_output("reset.out_valid", 64'(bus.out_valid), 64'd0);
        check_output("reset.out_data", 64'(bus.out_data), 64'd0);
        check_output("reset.in_ready", 64'(bus.in_ready), 64'd0);
        check_output("reset.route_err", 64'(route_err), 64'd0);
        rst = 1'b1;

        #1 check_output("first_grant.in_ready", 64'(bus.in_ready), 64'(3'b001));
        cycle("first_grant");

        apply_stimulus(3'b010, {4'd0, 4'd2, 4'd0}, {16'h0, 16'hA5A5, 16'h0}, 3'b111);
        #1 check_output("west_to_local.in_ready", 64'(bus.in_ready), 64'(3'b010));
        cycle("west_to_local");
        check_output("west_to_local.valid", 64'(bus.out_valid), 64'(3'b001));
        check_output("west_to_local.data", 64'(bus.out_data[15:0]), 64'(16'hA5A5));

        for (int k = 0; k < 4; k++) begin
            apply_stimulus(3'b001, {8'h00, local_dest[k]}, 48'(16'h0100 + k), 3'b111);
            cycle("route_dir");
            check_output("route_dir.valid", 64'(bus.out_valid), 64'(1 << local_port[k]));
            check_output("route_dir.data", 64'(bus.out_data[DW*local_port[k] +: DW]), 64'(16'h0100 + k));
        end

        apply_stimulus(3'b001, {8'h00, 4'd3}, 48'h1234, 3'b111);
        cycle("bp_load");
        apply_stimulus(3'b001, {8'h00, 4'd3}, 48'h5678, 3'b011);
        repeat (4) begin
            #1 check_output("bp_stall.in_ready0", 64'(bus.in_ready[0]), 64'd0);
            cycle("bp_stall");
            check_output("bp_stall.hold", 64'(bus.out_data[47:32]), 64'(16'h1234));
        end
        apply_stimulus(3'b001, {8'h00, 4'd3}, 48'h5678, 3'b111);
        cycle("bp_release");
        check_output("bp_release.data", 64'(bus.out_data[47:32]), 64'(16'h5678));

        apply_stimulus(3'b001, {8'h00, 4'd9}, 48'hBEEF, 3'b111);
        cycle("bad_dest");
        check_output("bad_dest.data", 64'(bus.out_data[15:0]), 64'(16'hBEEF));
        check_output("bad_dest.err", 64'(route_err), 64'd1);
        apply_stimulus(3'b000, 12'h000, 48'h0, 3'b111);
        repeat (3) cycle("err_sticky");
        check_output("err_sticky.err", 64'(route_err), 64'd1);

        apply_stimulus(3'b111, {4'd3, 4'd0, 4'd2}, 48'h3333_2222_1111, 3'b111);
        cycle("all_out");
        check_output("all_out.valid", 64'(bus.out_valid), 64'(3'b111));
        #2 rst = 1'b0;
        #1;
        check_output("async_rst.out_valid", 64'(bus.out_valid), 64'd0);
        check_output("async_rst.out_data", 64'(bus.out_data), 64'd0);
        check_output("async_rst.in_ready", 64'(bus.in_ready), 64'd0);
        check_output("async_rst.route_err", 64'(route_err), 64'd0);
        model_reset();
        apply_stimulus(3'b000, 12'h000, 48'h0, 3'b111);
        @(posedge clk);
        #1 rst = 1'b1;

        apply_stimulus(3'b111, {4'd3, 4'd3, 4'd3}, 48'h00C2_00C1_00C0, 3'b111);
        for (int k = 0; k < 4; k++) begin
            #1 check_output("contend.in_ready", 64'(bus.in_ready), 64'(rr_seq[k]));
            cycle("contend");
            check_output("contend.east_valid", 64'(bus.out_valid[2]), 64'd1);
        end

        repeat (400) begin
            apply_stimulus(3'($urandom), 12'($urandom), 48'({$urandom, $urandom}),
                           3'($urandom | $urandom));
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ring_port_arbiter.md
RING_PORT_ARBITER -- requirements
Module: ring_port_arbiter

Interface
REQ-001 Parameter: ADDR, default 4'd0, this node's 4-bit ring address.
REQ-002 Parameter: N, default 4'd8, ring node count, legal range 2..15; ADDR < N.
REQ-003 Parameter: DW, default 16, flit data width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  3  flit offered per input port; index 0=local, 1=west, 2=east.
REQ-007 in_dest  input  12  destination address per input, input i at bits [4i+3:4i].
REQ-008 in_data  input  3*DW  flit payload per input, input i at bits [DW*i+DW-1:DW*i].
REQ-009 in_ready  output  3  combinational grant per input; a flit transfers when in_valid[i] and in_ready[i] are both 1.
REQ-010 out_valid  output  3  registered flit valid per output port (0=local, 1=west, 2=east).
REQ-011 out_data  output  3*DW  registered payload per output port, packed as in_data.
REQ-012 out_ready  input  3  downstream accept per output port.
REQ-013 route_err  output  1  sticky flag: a flit with in_dest >= N was accepted.

Function
REQ-014 Route per input, combinational: diff = |dest - ADDR|, ndiff = N - diff.
REQ-015 dest == ADDR routes to local (0).
REQ-016 dest < ADDR: diff >= ndiff routes east (2); otherwise west (1).
REQ-017 dest > ADDR: diff >= ndiff routes west (1); otherwise east (2).
REQ-018 dest >= N routes to local (0), and its acceptance sets route_err.
REQ-019 A west-in or east-in flit may route back out of the same port; no U-turn filtering.
REQ-020 Output o is free in a cycle when out_valid[o] == 0 or out_ready[o] == 1.
REQ-021 Each output has a 2-bit round-robin pointer ptr[o] (values 0..2).
  - When output o is free, it grants the first valid input routed to o, searching ptr[o], ptr[o]+1, ptr[o]+2 mod 3.
REQ-022 in_ready[i] = 1 only when input i is valid, its routed output is free, and that output's arbitration selects i.
  - At most one in_ready per output; at most one output per input.
REQ-023 On a grant, at the next edge: out_data[o] loads the granted payload, out_valid[o] = 1, ptr[o] = (granted index + 1) mod 3.
REQ-024 Output free with no routed valid input: out_valid[o] clears to 0; ptr[o] and out_data[o] hold.
REQ-025 out_valid[o] = 1 and out_ready[o] = 0: out_valid[o] and out_data[o] hold stable; in_ready = 0 for every input routed to o.
REQ-026 Latency: accepted flit appears on out_valid/out_data exactly 1 cycle after the transfer edge.
  - Full throughput is 1 flit/cycle/output when out_ready is held at 1.
REQ-027 Simultaneous pop and grant on one output in the same cycle is a normal case; no bubble is inserted.
REQ-028 The three outputs arbitrate independently and concurrently.
  - Up to 3 transfers per cycle when inputs target distinct outputs.
REQ-029 in_ready shall not depend on in_data.

Reset
REQ-030 While rst = 0, all of the following hold:
  - out_valid = 0, out_data = 0, ptr[0..2] = 0, route_err = 0.
  - in_ready = 0 combinationally.
REQ-031 Reset asserted mid-transfer discards all held flits; no partial state survives.
REQ-032 route_err clears only by reset.
REQ-033 After rst deasserts, the first grant may occur in the first clock cycle.

Verification (N=8, ADDR=2, DW=16)
REQ-034 West in_valid, dest=2, data=16'hA5A5, all out_ready=1 -> in_ready[1]=1; next cycle out_valid=3'b001, local data=16'hA5A5.
REQ-035 Single local flits with dest=6, 5, 0, 3 -> routed to west, east, west, east respectively (6: diff=4/ndiff=4; 0: diff=2/ndiff=6).
REQ-036 Contention: all three inputs valid with dest=3, held valid, out_ready=1 -> grants to inputs 0, 1, 2 on consecutive cycles, then 0 again; out_valid[2] stays 1 throughout.
REQ-037 Backpressure: out_valid[2]=1, data=16'h1234, out_ready[2]=0 for 4 cycles, local dest=3 valid -> in_ready[0]=0 and data holds 16'h1234; on out_ready[2]=1 the new flit loads at the next edge.
REQ-038 Local dest=9 -> flit on local output; route_err=1 and stays 1 until rst=0.
REQ-039 rst=0 asserted asynchronously while out_valid=3'b111 -> out_valid=0 immediately, before the next clock edge; ptr reset verified by a subsequent contention test starting at input 0.
